// File: rtl/ro_rx_demux.sv
// Readout-bus receiver: tracks the transmit-side gray counter, captures the
// shared event lines of the active core, and queues tagged events in a FIFO.
module ro_rx_demux #(
   parameter int CW    = 19,
   parameter int DEPTH = 4
) (
   input  logic          clk_master,
   input  logic          reset,
   input  logic          sync,
   input  logic          rd_eve,
   input  logic          rd_pol_eve,
   input  logic          out_ready,
   input  logic          ovf_clr,
   output logic          out_valid,
   output logic [4:0]    out_chan,
   output logic          out_eve,
   output logic          out_pol_eve,
   output logic [CW-1:0] out_ts,
   output logic          overflow
);

   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
   localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);

   // Gray bit that toggles when the counter reaches v: lowest set bit of v,
   // or the top channel when v wrapped to zero.
   function automatic logic [4:0] chan_of(input logic [CW-1:0] v);
      logic [4:0] k;
      k = 5'(CW-1);
      for (int i = CW-1; i >= 0; i--) begin
         if (v[i]) begin
            k = 5'(i);
         end
      end
      return k;
   endfunction

   logic [CW-1:0] cnt_r;
   logic          cap_eve_r;
   logic          cap_pol_r;
   logic [4:0]    cap_k_r;
   logic [CW-1:0] cap_ts_r;

   logic [4:0]    mem_k_r   [DEPTH];
   logic          mem_eve_r [DEPTH];
   logic          mem_pol_r [DEPTH];
   logic [CW-1:0] mem_ts_r  [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW:0]   fill_r;
   logic          ovf_r;

   logic          valid_s;
   logic          full_s;
   logic          push_s;
   logic          pop_s;
   logic          wr_en_s;
   logic          drop_s;

   // Local copy of the transmit counter; sync realigns it to zero.
   always_ff @(posedge clk_master or posedge reset) begin
      if (reset) begin
         cnt_r <= {CW{1'b0}};
      end else if (sync) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // Bus lines are stable mid high-phase, so sample them on the falling edge
   // together with the channel and timestamp of the count just entered.
   always_ff @(negedge clk_master or posedge reset) begin
      if (reset) begin
         cap_eve_r <= 1'b0;
         cap_pol_r <= 1'b0;
         cap_k_r   <= 5'd0;
         cap_ts_r  <= {CW{1'b0}};
      end else begin
         cap_eve_r <= rd_eve;
         cap_pol_r <= rd_pol_eve;
         cap_k_r   <= chan_of(cnt_r);
         cap_ts_r  <= cnt_r;
      end
   end

   // FIFO handshake decode; a pop frees the slot a same-edge push needs.
   always_comb begin
      valid_s = (fill_r != {(AW+1){1'b0}});
      full_s  = (fill_r == FILL_MAX);
      push_s  = cap_eve_r | cap_pol_r;
      pop_s   = valid_s & out_ready;
      wr_en_s = push_s & (~full_s | pop_s);
      drop_s  = push_s & full_s & ~pop_s;
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk_master or posedge reset) begin
      if (reset) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         fill_r   <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_k_r[i]   <= 5'd0;
            mem_eve_r[i] <= 1'b0;
            mem_pol_r[i] <= 1'b0;
            mem_ts_r[i]  <= {CW{1'b0}};
         end
      end else begin
         if (wr_en_s) begin
            mem_k_r[wr_ptr_r]   <= cap_k_r;
            mem_eve_r[wr_ptr_r] <= cap_eve_r;
            mem_pol_r[wr_ptr_r] <= cap_pol_r;
            mem_ts_r[wr_ptr_r]  <= cap_ts_r;
            wr_ptr_r            <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({wr_en_s, pop_s})
            2'b10:   fill_r <= fill_r + FILL_ONE;
            2'b01:   fill_r <= fill_r - FILL_ONE;
            default: fill_r <= fill_r;
         endcase
      end
   end

   // Sticky overflow; a drop in the clearing cycle keeps it set.
   always_ff @(posedge clk_master or posedge reset) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else if (drop_s) begin
         ovf_r <= 1'b1;
      end else if (ovf_clr) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   // Head entry presented straight from storage; zeros while empty.
   always_comb begin
      out_valid   = valid_s;
      overflow    = ovf_r;
      out_chan    = 5'd0;
      out_eve     = 1'b0;
      out_pol_eve = 1'b0;
      out_ts      = {CW{1'b0}};
      if (valid_s) begin
         out_chan    = mem_k_r[rd_ptr_r];
         out_eve     = mem_eve_r[rd_ptr_r];
         out_pol_eve = mem_pol_r[rd_ptr_r];
         out_ts      = mem_ts_r[rd_ptr_r];
      end else begin
         out_chan    = 5'd0;
         out_eve     = 1'b0;
         out_pol_eve = 1'b0;
         out_ts      = {CW{1'b0}};
      end
   end

endmodule

// File: tb/tb_ro_rx_demux.sv
// Bench for ro_rx_demux: directed table, corner sequences and a randomized run
// against a queue-based model of the receive rules.
module tb_ro_rx_demux;

   localparam int CW    = 19;
   localparam int DEPTH = 4;

   logic          clk_master = 1'b0;
   logic          reset = 1'b1;
   logic          sync = 1'b0;
   logic          rd_eve = 1'b0;
   logic          rd_pol_eve = 1'b0;
   logic          out_ready = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          out_valid;
   logic [4:0]    out_chan;
   logic          out_eve;
   logic          out_pol_eve;
   logic [CW-1:0] out_ts;
   logic          overflow;
   logic          out_valid4;
   logic [4:0]    out_chan4;
   logic          out_eve4;
   logic          out_pol_eve4;
   logic [3:0]    out_ts4;
   logic          overflow4;

   ro_rx_demux #(.CW(CW), .DEPTH(DEPTH)) dut (
      .clk_master(clk_master), .reset(reset), .sync(sync), .rd_eve(rd_eve),
      .rd_pol_eve(rd_pol_eve), .out_ready(out_ready), .ovf_clr(ovf_clr),
      .out_valid(out_valid), .out_chan(out_chan), .out_eve(out_eve),
      .out_pol_eve(out_pol_eve), .out_ts(out_ts), .overflow(overflow));

   ro_rx_demux #(.CW(4), .DEPTH(4)) dut4 (
      .clk_master(clk_master), .reset(reset), .sync(sync), .rd_eve(rd_eve),
      .rd_pol_eve(rd_pol_eve), .out_ready(out_ready), .ovf_clr(ovf_clr),
      .out_valid(out_valid4), .out_chan(out_chan4), .out_eve(out_eve4),
      .out_pol_eve(out_pol_eve4), .out_ts(out_ts4), .overflow(overflow4));

   always #5 clk_master = ~clk_master;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit e; bit p; bit rdy; bit clr;
      bit v; int ch; bit ee; bit ep; int ts; bit ovf;
   } tv_t;

   typedef struct {
      int k; bit e; bit p; int ts;
   } ent_t;

   ent_t q[$];
   int   m_cnt;
   bit   pend_e, pend_p, m_ovf;
   int   pend_k, pend_ts;

   task automatic check(input string name, input bit ev, input int ech, input bit ee,
                        input bit ep, input int ets, input bit eovf);
      n_vec++;
      if (out_valid !== ev || out_chan !== 5'(ech) || out_eve !== ee ||
          out_pol_eve !== ep || out_ts !== CW'(ets) || overflow !== eovf) begin
         n_err++;
         $display("FAIL %s: got v=%0b ch=%0d eve=%0b pol=%0b ts=%0d ovf=%0b, expected v=%0b ch=%0d eve=%0b pol=%0b ts=%0d ovf=%0b",
                  name, out_valid, out_chan, out_eve, out_pol_eve, out_ts, overflow,
                  ev, ech, ee, ep, ets, eovf);
      end
   endtask

   task automatic check4(input string name, input bit ev, input int ech, input bit ee,
                         input bit ep, input int ets);
      n_vec++;
      if (out_valid4 !== ev || out_chan4 !== 5'(ech) || out_eve4 !== ee ||
          out_pol_eve4 !== ep || out_ts4 !== 4'(ets)) begin
         n_err++;
         $display("FAIL %s: got v=%0b ch=%0d eve=%0b pol=%0b ts=%0d, expected v=%0b ch=%0d eve=%0b pol=%0b ts=%0d",
                  name, out_valid4, out_chan4, out_eve4, out_pol_eve4, out_ts4,
                  ev, ech, ee, ep, ets);
      end
   endtask

   // Toggling gray bit for count value v of a w-bit counter.
   function automatic int chan_of(input int v, input int w);
      int k;
      int x;
      if (v == 0) return w - 1;
      k = 0;
      x = v;
      while (x % 2 == 0) begin
         x = x / 2;
         k++;
      end
      return k;
   endfunction

   task automatic model_reset();
      q.delete();
      m_cnt  = 0;
      pend_e = 1'b0;
      pend_p = 1'b0;
      pend_k = 0;
      pend_ts = 0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_edge(input bit rdy, input bit clr, input bit syn);
      bit   drop;
      ent_t n;
      drop = 1'b0;
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (pend_e || pend_p) begin
         if (q.size() < DEPTH) begin
            n.k = pend_k; n.e = pend_e; n.p = pend_p; n.ts = pend_ts;
            q.push_back(n);
         end else begin
            drop = 1'b1;
         end
      end
      if (clr) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
      m_cnt = syn ? 0 : (m_cnt + 1) % (1 << CW);
   endtask

   task automatic model_phase(input bit e, input bit p);
      pend_e  = e;
      pend_p  = p;
      pend_k  = chan_of(m_cnt, CW);
      pend_ts = m_cnt;
   endtask

   task automatic check_model(input string name);
      if (q.size() > 0) check(name, 1'b1, q[0].k, q[0].e, q[0].p, q[0].ts, m_ovf);
      else              check(name, 1'b0, 0, 1'b0, 1'b0, 0, m_ovf);
   endtask

   task automatic do_reset();
      @(posedge clk_master); #1;
      reset = 1'b1; sync = 1'b0; rd_eve = 1'b0; rd_pol_eve = 1'b0;
      out_ready = 1'b0; ovf_clr = 1'b0;
      @(posedge clk_master); #1;
      check("reset_state", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      reset = 1'b0;
      model_reset();
   endtask

   tv_t tbl[12];

   initial begin
      // inputs {e,p,rdy,clr} driven after edge k; expected head after edge k
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,0,1'b0};
      tbl[1]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,0,1'b1,1'b0,1,1'b0};
      tbl[2]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,0,1'b1,1'b0,1,1'b0};
      tbl[3]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,0,1'b1,1'b0,1,1'b0};
      tbl[4]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,0,1'b1,1'b0,1,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,0,1'b1,1'b0,1,1'b1};
      tbl[6]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1,1'b1,1'b0,2,1'b1};
      tbl[7]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,0,1'b1,1'b0,3,1'b1};
      tbl[8]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,2,1'b1,1'b1,4,1'b1};
      tbl[9]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,0,1'b0,1'b0,0,1'b1};
      tbl[10] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,0,1'b0};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,0,1'b0};

      // Fill to overflow, drain in order, clear the flag.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(posedge clk_master); #1;
         check($sformatf("table_%0d", i), tbl[i].v, tbl[i].ch, tbl[i].ee,
               tbl[i].ep, tbl[i].ts, tbl[i].ovf);
         rd_eve     = tbl[i].e;
         rd_pol_eve = tbl[i].p;
         out_ready  = tbl[i].rdy;
         ovf_clr    = tbl[i].clr;
      end
      out_ready = 1'b0; ovf_clr = 1'b0;

      // Idle bus for 64 cycles, then one event tagged with count 64.
      do_reset();
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk_master); #1;
         if (i % 16 == 0) check($sformatf("idle_%0d", i), 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      end
      rd_pol_eve = 1'b1;
      @(posedge clk_master); #1;
      rd_pol_eve = 1'b0;
      check("ts64_entry", 1'b1, 6, 1'b0, 1'b1, 64, 1'b0);
      check4("cw4_wrap_clamp", 1'b1, 3, 1'b0, 1'b1, 0);

      // Reset while entries are queued and overflow is set.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk_master); #1;
         rd_eve = 1'b1;
      end
      @(posedge clk_master); #1;
      rd_eve = 1'b0;
      check("pre_reset", 1'b1, 0, 1'b1, 1'b0, 1, 1'b1);
      #2 reset = 1'b1;
      #1 check("async_reset", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      @(posedge clk_master); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_master); #1;
         check("post_reset", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      end

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk_master);
         model_edge(out_ready, ovf_clr, sync);
         #1;
         check_model("random");
         rd_eve     = ($urandom_range(0, 2) == 0);
         rd_pol_eve = ($urandom_range(0, 2) == 0);
         out_ready  = ($urandom_range(0, 4) < 2);
         ovf_clr    = ($urandom_range(0, 15) == 0);
         sync       = ($urandom_range(0, 63) == 0);
         model_phase(rd_eve, rd_pol_eve);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
